// File: rtl/led_cnt_pkg.sv
// Shared types and defaults for the multi-channel LED blinker / interrupt counter.
// Optional PWM dimming is enabled by defining LED_CNT_PWM_EN.
package led_cnt_pkg;

  localparam int DIV_W_DEF = 12;
  localparam int CNT_W_DEF = 32;
  localparam int PWM_W     = 4;

  // A channel is idle while its programmed period is zero.
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Per-channel status as seen by software.
  typedef struct packed {
    logic                 led;
    logic                 irq;
    logic [CNT_W_DEF-1:0] cnt;
  } ch_status_t;

endpackage

// File: rtl/led_cnt_ch.sv
// One LED channel: period register, tick counter, LED level, sticky
// interrupt flag and wrapping event counter. Channel state (idle/run) is
// derived from the period register and is visible as `state`.
//
// Strobes: wren and int_clr are single-cycle pulses with no ready side; a
// pulse is consumed on the clock edge where it is high. A write takes
// priority over a coincident tick, and a rising-edge event takes priority
// over a coincident clear.
module led_cnt_ch
  import led_cnt_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wren,
  input  logic [DIV_W-1:0] div_in,
  input  logic             int_clr,
  output logic             led_q,
  output logic             led_int,
  output logic [CNT_W-1:0] int_cnt
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] tick_cnt;
  logic [DIV_W-1:0] tick_cnt_nxt;
  logic             led_nxt;
  logic             led_int_nxt;
  logic             rise;
  logic [CNT_W-1:0] int_cnt_nxt;
  ch_state_e        state;

  // Channel runs whenever a nonzero period is loaded.
  always_comb state = (div_q == '0) ? CH_IDLE : CH_RUN;

  // Next-state: period load, tick counting, LED toggle and event bookkeeping.
  always_comb begin
    div_nxt      = div_q;
    tick_cnt_nxt = tick_cnt;
    led_nxt      = led_q;
    if (wren) begin
      div_nxt      = div_in;
      tick_cnt_nxt = '0;
      if (div_in == '0) led_nxt = 1'b0;
    end else if (state == CH_RUN && tick) begin
      if (tick_cnt == div_q - DIV_W'(1)) begin
        tick_cnt_nxt = '0;
        led_nxt      = ~led_q;
      end else begin
        tick_cnt_nxt = tick_cnt + DIV_W'(1);
      end
    end
    rise        = led_nxt & ~led_q;
    led_int_nxt = led_int;
    if (rise)         led_int_nxt = 1'b1;
    else if (int_clr) led_int_nxt = 1'b0;
    int_cnt_nxt = int_cnt + CNT_W'(rise);
  end

  // Channel registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      tick_cnt <= '0;
      led_q    <= 1'b0;
      led_int  <= 1'b0;
      int_cnt  <= '0;
    end else begin
      div_q    <= div_nxt;
      tick_cnt <= tick_cnt_nxt;
      led_q    <= led_nxt;
      led_int  <= led_int_nxt;
      int_cnt  <= int_cnt_nxt;
    end
  end

endmodule

// File: rtl/led_cnt_mc.sv
// Multi-channel LED blinker / interrupt counter. NCH independent channels
// share one prescaler tick; irq_o is the registered OR of all sticky flags.
// Defining LED_CNT_PWM_EN adds a duty_i port that dims each LED with a
// free-running 4-bit PWM; events are always taken from the undimmed level.
module led_cnt_mc
  import led_cnt_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PRESCALE = 100000
) (
  input  logic                 clk100,
  input  logic                 rst,
  input  logic [NCH*DIV_W-1:0] div_i,
  input  logic [NCH-1:0]       wren_i,
  input  logic [NCH-1:0]       int_clr_i,
`ifdef LED_CNT_PWM_EN
  input  logic [NCH*PWM_W-1:0] duty_i,
`endif
  output logic [NCH*CNT_W-1:0] int_cnt_o,
  output logic [NCH-1:0]       led_int_o,
  output logic [NCH-1:0]       led_o,
  output logic                 irq_o
);

  localparam int              PRE_W    = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [NCH-1:0]   led_q;

  assign tick = (pre_cnt == PRE_LAST);

  // Prescaler: 0..PRESCALE-1, tick on the last count.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst)       pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PRE_W'(1);
  end

  // Interrupt line lags the sticky flags by one cycle.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) irq_o <= 1'b0;
    else     irq_o <= |led_int_o;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    led_cnt_ch #(
      .DIV_W (DIV_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk100),
      .rst     (rst),
      .tick    (tick),
      .wren    (wren_i[c]),
      .div_in  (div_i[c*DIV_W +: DIV_W]),
      .int_clr (int_clr_i[c]),
      .led_q   (led_q[c]),
      .led_int (led_int_o[c]),
      .int_cnt (int_cnt_o[c*CNT_W +: CNT_W])
    );
  end

`ifdef LED_CNT_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  // Free-running PWM phase shared by all channels.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  for (genvar c = 0; c < NCH; c++) begin : g_pwm
    assign led_o[c] = led_q[c] & (pwm_cnt < duty_i[c*PWM_W +: PWM_W]);
  end
`else
  assign led_o = led_q;
`endif

endmodule

// File: tb/tb_led_cnt_mc.sv
// Randomized self-checking bench for led_cnt_mc (PRESCALE=10, NCH=4, CNT_W=4
// so that counter wrap is reachable). The reference model describes each
// channel as "ticks since last write": the LED level is the level at write
// time XOR the parity of (ticks / period).
module tb_led_cnt_mc;
  import led_cnt_pkg::*;

  localparam int NCH      = 4;
  localparam int DIV_W    = 12;
  localparam int CNT_W    = 4;
  localparam int PRESCALE = 10;
  localparam int W        = NCH*CNT_W + 2*NCH + 1;
  localparam logic [CNT_W_DEF-1:0] CNT_MASK = (CNT_W_DEF'(1) << CNT_W) - CNT_W_DEF'(1);

  // ---------------- clock / reset ----------------
  logic clk100 = 1'b0;
  logic rst    = 1'b1;
  always #5 clk100 = ~clk100;

  logic [NCH*DIV_W-1:0] div_i     = '0;
  logic [NCH-1:0]       wren_i    = '0;
  logic [NCH-1:0]       int_clr_i = '0;
  logic [NCH*CNT_W-1:0] int_cnt_o;
  logic [NCH-1:0]       led_int_o;
  logic [NCH-1:0]       led_o;
  logic                 irq_o;
`ifdef LED_CNT_PWM_EN
  logic [NCH*4-1:0]     duty_i = {NCH{4'd15}};
`endif

  led_cnt_mc #(
    .NCH      (NCH),
    .DIV_W    (DIV_W),
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk100    (clk100),
    .rst       (rst),
    .div_i     (div_i),
    .wren_i    (wren_i),
    .int_clr_i (int_clr_i),
`ifdef LED_CNT_PWM_EN
    .duty_i    (duty_i),
`endif
    .int_cnt_o (int_cnt_o),
    .led_int_o (led_int_o),
    .led_o     (led_o),
    .irq_o     (irq_o)
  );

  // ---------------- checker ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  ch_status_t m_st   [NCH];
  int         m_div  [NCH];
  int         m_n    [NCH];
  logic       m_base [NCH];
  logic       m_irq = 1'b0;
  int         k     = 0;   // clock edges since reset release
`ifdef LED_CNT_PWM_EN
  int         m_pwm = 0;
`endif
  logic [W-1:0] exp_q[$];

  always @(posedge clk100) begin
    logic [W-1:0] e;
    logic         any_flag;
    logic         tk;
    logic         old;
    logic         rise;
    logic         gate;
    int           dv;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_st[c] = '0; m_div[c] = 0; m_n[c] = 0; m_base[c] = 1'b0;
      end
      m_irq = 1'b0;
      k     = 0;
`ifdef LED_CNT_PWM_EN
      m_pwm = 0;
`endif
    end else begin
      tk       = ((k % PRESCALE) == PRESCALE - 1);
      any_flag = 1'b0;
      for (int c = 0; c < NCH; c++) any_flag |= m_st[c].irq;
      for (int c = 0; c < NCH; c++) begin
        old = m_st[c].led;
        if (wren_i[c]) begin
          dv       = int'(div_i[c*DIV_W +: DIV_W]);
          m_div[c] = dv;
          m_n[c]   = 0;
          if (dv == 0) m_st[c].led = 1'b0;
          m_base[c] = m_st[c].led;
        end else if (m_div[c] != 0 && tk) begin
          m_n[c]++;
          m_st[c].led = m_base[c] ^ (((m_n[c] / m_div[c]) % 2) != 0);
        end
        rise = !old && m_st[c].led;
        if (rise) begin
          m_st[c].irq = 1'b1;
          m_st[c].cnt = (m_st[c].cnt + 1) & CNT_MASK;
        end else if (int_clr_i[c]) begin
          m_st[c].irq = 1'b0;
        end
      end
      m_irq = any_flag;
      k++;
`ifdef LED_CNT_PWM_EN
      m_pwm = (m_pwm + 1) % 16;
`endif
    end
    e = '0;
    e[W-1] = m_irq;
    for (int c = 0; c < NCH; c++) begin
`ifdef LED_CNT_PWM_EN
      gate = (m_pwm < int'(duty_i[c*4 +: 4]));
`else
      gate = 1'b1;
`endif
      e[c*CNT_W +: CNT_W]     = m_st[c].cnt[CNT_W-1:0];
      e[NCH*CNT_W + c]        = m_st[c].led & gate;
      e[NCH*CNT_W + NCH + c]  = m_st[c].irq;
    end
    exp_q.push_back(e);
  end

  // Would the next clock edge produce a rising-edge event on channel c
  // (assuming no write to it)?
  function automatic logic will_rise(input int c);
    if (m_div[c] == 0 || (k % PRESCALE) != PRESCALE - 1 || m_st[c].led) return 1'b0;
    return m_base[c] ^ ((((m_n[c] + 1) / m_div[c]) % 2) != 0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_all();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check("irq_o",     irq_o,     e[W-1]);
    check("led_int_o", led_int_o, e[NCH*CNT_W + NCH +: NCH]);
    check("led_o",     led_o,     e[NCH*CNT_W +: NCH]);
    check("int_cnt_o", int_cnt_o, e[NCH*CNT_W-1:0]);
  endtask

  task automatic step();
    @(negedge clk100);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_div(input int c, input int v);
    div_i[c*DIV_W +: DIV_W] = DIV_W'(v);
    wren_i[c] = 1'b1;
    step();
    wren_i = '0;
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int c);
    return int_cnt_o[c*CNT_W +: CNT_W];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [CNT_W-1:0] saved;
    int  kw, kc, nt;
    bit  done, got15;

    // Reset held for 5 cycles.
    run(5);
    check("rst_led",  led_o,     64'd0);
    check("rst_int",  led_int_o, 64'd0);
    check("rst_irq",  irq_o,     64'd0);
    check("rst_cnt",  int_cnt_o, 64'd0);
    rst = 1'b0;

    // No writes: everything stays dark and quiet.
    run(1000);
    check("idle_cnt", int_cnt_o, 64'd0);
    check("idle_irq", irq_o,     64'd0);

    // ch0 period 3 ticks: a rising edge every 60 cycles.
    write_div(0, 3);
    run(600);
    check("ch0_cnt_600", (cnt_of(0) >= 9 && cnt_of(0) <= 11), 64'd1);
    check("ch0_flag", led_int_o[0], 64'd1);
    check("ch0_irq",  irq_o,        64'd1);

    // Clear coincident with an event: set wins.
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (will_rise(0)) begin
        int_clr_i[0] = 1'b1;
        step();
        int_clr_i = '0;
        check("clr_vs_set", led_int_o[0], 64'd1);
        done = 1'b1;
      end else begin
        step();
      end
    end
    if (!done) check("clr_vs_set_timeout", 64'd0, 64'd1);

    // Clear with no event pending.
    step();
    saved = cnt_of(0);
    int_clr_i[0] = 1'b1;
    step();
    int_clr_i = '0;
    check("clr_flag", led_int_o[0], 64'd0);
    step();
    check("clr_irq", irq_o,     64'd0);
    check("clr_cnt", cnt_of(0), saved);

    // ch1 period 2, then stopped mid-period, then restarted with period 5.
    write_div(1, 2);
    run(35);
    write_div(1, 0);
    check("ch1_stop_led", led_o[1], 64'd0);
    saved = cnt_of(1);
    run(200);
    check("ch1_stop_cnt", cnt_of(1), saved);
    check("ch1_stop_led2", led_o[1], 64'd0);
    div_i[1*DIV_W +: DIV_W] = DIV_W'(5);
    wren_i[1] = 1'b1;
    int_clr_i[1] = 1'b1;
    step();
    wren_i = '0;
    int_clr_i = '0;
    kw = k - 1;
    kc = -1;
    for (int i = 0; i < 100 && kc < 0; i++) begin
      step();
      if (led_int_o[1]) kc = k - 1;
    end
    if (kc < 0) check("ch1_div5_timeout", 64'd0, 64'd1);
    else begin
      nt = 0;
      for (int j = kw + 1; j <= kc; j++) if ((j % PRESCALE) == PRESCALE - 1) nt++;
      check("ch1_div5_ticks", nt, 64'd5);
    end

    // ch2 period 1 until its 4-bit event counter wraps.
    write_div(2, 1);
    got15 = 1'b0;
    done  = 1'b0;
    for (int i = 0; i < 800 && !done; i++) begin
      step();
      if (!got15 && cnt_of(2) == CNT_W'(15)) begin
        got15 = 1'b1;
        int_clr_i[2] = 1'b1;
        step();
        int_clr_i = '0;
        check("ch2_pre_wrap_flag", led_int_o[2], 64'd0);
      end else if (got15 && cnt_of(2) != CNT_W'(15)) begin
        check("ch2_wrap_cnt",  cnt_of(2),    64'd0);
        check("ch2_wrap_flag", led_int_o[2], 64'd1);
        done = 1'b1;
      end
    end
    if (!done) check("ch2_wrap_timeout", 64'd0, 64'd1);

    // Random writes and clears on all channels.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        int c;
        c = $urandom_range(0, NCH - 1);
        div_i[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 4));
        wren_i[c] = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) int_clr_i = NCH'($urandom_range(0, (1 << NCH) - 1));
`ifdef LED_CNT_PWM_EN
      if ($urandom_range(0, 99) == 0) duty_i = (NCH*4)'($urandom);
`endif
      step();
      wren_i    = '0;
      int_clr_i = '0;
    end

    // Asynchronous reset in the middle of a period.
    for (int c = 0; c < NCH; c++) write_div(c, c + 1);
    run(137);
    #2 rst = 1'b1;
    #1;
    check("arst_led", led_o,     64'd0);
    check("arst_int", led_int_o, 64'd0);
    check("arst_irq", irq_o,     64'd0);
    check("arst_cnt", int_cnt_o, 64'd0);
    run(3);
    rst = 1'b0;
    run(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
